// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin arbiter sharing one pipelined multiplier
// between N_REQ requesters; products return tagged, in accept order.
//
// Ports:
//   sys_clk       clock, all state on rising edge
//   sys_rst_n     asynchronous active-low reset
//   req           per-requester request, held with operands until granted
//   op_a, op_b    flattened operands, slice k belongs to requester k
//   grant         combinational one-hot grant (zero in reset / no request)
//   res_valid     one-hot pulse identifying the owner of res_data
//   res_data      low WIDTH bits of the product, holds when idle
//   busy          any accepted operation still in the pipeline
//   conflict_cnt  wrapping count of cycles with two or more requests
module mul_share_arbiter #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   op_a,
   input  logic [N_REQ*WIDTH-1:0]   op_b,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         res_valid,
   output logic [WIDTH-1:0]         res_data,
   output logic                     busy,
   output logic [31:0]              conflict_cnt
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [PTR_W-1:0] r_ptr;
   logic [MUL_LAT-1:0] r_vld;
   logic [PTR_W-1:0] r_tag [MUL_LAT];
   logic [WIDTH-1:0] r_data [MUL_LAT];
   logic [31:0] r_conf_cnt;

   logic [N_REQ-1:0] w_grant;
   logic [PTR_W-1:0] w_idx;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_prod;
   logic w_acc;
   logic w_conf;
   int v_best;
   int v_dist;

   // Rank every request by its distance from ptr+1 (mod N_REQ) and
   // pick the closest; this avoids a data-dependent vector index.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      v_best  = N_REQ;
      v_dist  = 0;
      for (int k = 0; k < N_REQ; k++) begin
         v_dist = (k + N_REQ - int'(r_ptr) - 1) % N_REQ;
         if (req[k] && (v_dist < v_best)) begin
            v_best = v_dist;
            w_idx  = PTR_W'(k);
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         w_grant[k] = sys_rst_n && (v_best < N_REQ)
                      && (w_idx == PTR_W'(k));
      end
   end

   assign grant = w_grant;
   assign w_acc = |w_grant;

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_grant[k]) begin
            w_a = op_a[k*WIDTH +: WIDTH];
            w_b = op_b[k*WIDTH +: WIDTH];
         end
      end
   end

   // Low WIDTH bits are identical for signed and unsigned operands.
   assign w_prod = w_a * w_b;

   // Two or more bits set: clearing the lowest set bit leaves a one.
   assign w_conf = |(req & (req - N_REQ'(1)));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_ptr      <= PTR_W'(N_REQ - 1);
         r_conf_cnt <= '0;
      end else begin
         if (w_acc) begin
            r_ptr <= w_idx;
         end
         if (w_conf) begin
            r_conf_cnt <= r_conf_cnt + 32'd1;
         end
      end
   end

   // Valid bits always shift; tag and data load only behind a valid
   // entry so the last stage keeps the most recent completed product.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_vld <= '0;
         for (int s = 0; s < MUL_LAT; s++) begin
            r_tag[s]  <= '0;
            r_data[s] <= '0;
         end
      end else begin
         r_vld[0] <= w_acc;
         if (w_acc) begin
            r_tag[0]  <= w_idx;
            r_data[0] <= w_prod;
         end
         for (int s = 1; s < MUL_LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            if (r_vld[s-1]) begin
               r_tag[s]  <= r_tag[s-1];
               r_data[s] <= r_data[s-1];
            end
         end
      end
   end

   always_comb begin
      res_valid = '0;
      for (int k = 0; k < N_REQ; k++) begin
         res_valid[k] = r_vld[MUL_LAT-1]
                        && (r_tag[MUL_LAT-1] == PTR_W'(k));
      end
   end

   assign res_data     = r_data[MUL_LAT-1];
   assign busy         = |r_vld;
   assign conflict_cnt = r_conf_cnt;

endmodule
